// File: rtl/alu_serial.sv
// alu_serial: bit-serial N-bit ALU (NOR, XOR, ADD, SUB) built around one 1-bit slice.
// Operands are accepted on a valid/ready handshake, processed LSB-first at one bit per
// clock, and the result is held in DONE until the consumer accepts it.
// Optional feature macro: ALU_SERIAL_FLAGS_EN adds the o_zero / o_ovf status outputs.
module alu_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             o_zero,
    output logic             o_ovf
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OpNor = 2'b00;
    localparam logic [1:0] OpXor = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpSub = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [CntW-1:0]  r_cnt;
    logic             r_carry;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_arith;
    logic             w_carry_out;
    logic             w_res_bit;
    logic             w_carry_next;
    logic             w_last;
    logic [WIDTH-1:0] w_result_shift;

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_in_valid) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  if (i_out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // The single 1-bit slice; operands are shifted right so bit 0 is always the current bit.
    always_comb begin
        w_a_bit        = r_a[0];
        // SUB adds ~b with carry-in 1 (two's complement).
        w_b_bit        = (r_op == OpSub) ? ~r_b[0] : r_b[0];
        w_arith        = r_op[1];
        w_carry_out    = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));
        w_res_bit      = 1'b0;
        case (r_op)
            OpNor:   w_res_bit = ~(r_a[0] | r_b[0]);
            OpXor:   w_res_bit = r_a[0] ^ r_b[0];
            default: w_res_bit = w_a_bit ^ w_b_bit ^ r_carry;
        endcase
        w_carry_next   = w_arith & w_carry_out;
        w_last         = (r_cnt == CntW'(WIDTH - 1));
        w_result_shift = {w_res_bit, r_result[WIDTH-1:1]};
    end

    // Datapath: latch operands on accept, then shift one result bit into the MSB per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OpNor;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_op     <= i_op;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_carry  <= (i_op == OpSub);
                    end
                end
                StRun: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_result <= w_result_shift;
                    r_carry  <= w_carry_next;
                    r_cnt    <= w_last ? '0 : r_cnt + CntW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // Flags are captured from the final slice step; r_carry then holds the carry into the MSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == StIdle && i_in_valid) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == StRun && w_last) begin
            r_zero <= (w_result_shift == '0);
            r_ovf  <= w_arith & (r_carry ^ w_carry_out);
        end
    end

    assign o_zero = r_zero;
    assign o_ovf  = r_ovf;
`endif

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_result    = r_result;
    // Carry register is held at 0 for logic ops, so it doubles as cout.
    assign o_cout      = r_carry;

endmodule

// File: doc/alu_serial.md
# alu_serial

Bit-serial N-bit ALU built around a single 1-bit slice. It supports the same operation set as the 1-bit ALU: NOR, XOR, ADD and SUB. Operands are accepted through a valid/ready handshake and processed LSB-first, one bit per clock. The result is held until the consumer accepts it. It sits between operand sources and result consumers in the datapath, where area matters more than throughput.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  2  operation: 00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a-b).
- `out_valid`  out  1  result/cout valid; high in DONE.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  operation result.
- `cout`  out  1  final carry for ADD/SUB; 0 for NOR/XOR.
- `zero`, `ovf`  out  1 each  status flags; present only with `ALU_SERIAL_FLAGS_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: when `in_valid` is high on an edge, latch `a`, `b` and `op`, clear `result`, clear bit counter `cnt` (width $clog2(WIDTH)), go to RUN.
  - Carry register init on accept: 1 for SUB, 0 otherwise.
- RUN, each edge:
  - Bit `i = cnt` computed from `a[i]`, `b[i]` and carry.
  - NOR: `~(a|b)`. XOR: `a^b`. ADD: full-add. SUB: full-add with `~b[i]` (two's complement).
  - Result bit shifted into the MSB of `result` (shift right).
  - Carry register updated for ADD/SUB; held at 0 for NOR/XOR.
  - `cnt` increments; at `cnt == WIDTH-1` go to DONE.
- DONE: `result`, `cout` and flags held stable. When `out_ready` is high, go to IDLE.
- Latched operands mean `a`, `b` and `op` changes outside the accept edge have no effect.
- `in_valid` is ignored in RUN and DONE. There is no accept in the same cycle as the DONE→IDLE transition.
- SUB `cout` = 1 means no borrow (a ≥ b unsigned).
- Arithmetic wraps modulo 2^WIDTH. Carry beyond the MSB appears only on `cout`.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `result`=0, `cout`=0, `zero`=0, `ovf`=0.
  - `cnt`=0, carry=0.
- Latency: accept on edge k gives `out_valid`=1 after edge k+WIDTH. For WIDTH=8 that is 8 cycles.
- `in_ready` falls after the accept edge and rises after the edge where `out_valid && out_ready`.
- Minimum issue interval is WIDTH+2 cycles: WIDTH RUN cycles, at least one DONE cycle, one IDLE cycle.
- `result` during RUN holds partial shift contents. It is only checked while `out_valid`=1.
- `rst` in any state returns the block to reset values on that edge. An in-flight operation is discarded with no `out_valid` pulse.
- `rst` and `in_valid` on the same edge: reset wins and nothing is accepted.

## Configuration
- `ALU_SERIAL_FLAGS_EN` defined: `zero` and `ovf` ports exist. Both are updated on the RUN→DONE transition and held through DONE.
  - `zero` = (final `result` == 0), for all ops.
  - `ovf` = signed overflow (carry into MSB XOR carry out of MSB) for ADD/SUB; 0 for NOR/XOR.
  - Both are cleared on accept and on reset.
- Not defined: no `zero`/`ovf` ports and no flag logic. All other behaviour is identical.

## Test plan
- WIDTH=8, ADD a=200, b=100 → `out_valid` 8 cycles after accept, `result`=44, `cout`=1; `ovf`=0 (flags build).
- SUB a=5, b=7 → `result`=0xFE, `cout`=0.
- SUB a=0x33, b=0x33 → `result`=0, `cout`=1, `zero`=1.
- NOR a=0xF0, b=0x0F → `result`=0x00, `cout`=0. XOR a=0xAA, b=0xFF → `result`=0x55.
- ADD a=0x7F, b=0x01 → `result`=0x80, `ovf`=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and `a`/`b` → `result` stable, `in_ready`=0, no new accept.
  - Then `out_ready`=1 → IDLE next edge.
  - Assert `rst` at `cnt`=3 → next cycle `in_ready`=1, `out_valid`=0, `result`=0, with no spurious `out_valid` afterwards.
